unidad_control_id: RTL

Registered main decode stage of the RISC-V core, sitting between the IF/ID and ID/EX pipeline registers. Each accepted 32-bit instruction is decoded into the 3-bit ALUOP and 4-bit INSTRUCCION codes consumed by the ALU control. It also produces the datapath control strobes, register indices and sign-extended immediate, all presented one cycle later. Stall holds the stage; flush inserts a bubble.

---
 rtl/unidad_control_id.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/unidad_control_id.sv
// -----------------------------------------------------------------------------
// unidad_control_id
// Registered main decode stage of the RISC-V core (between IF/ID and ID/EX).
// Every accepted instruction word is decoded into the ALU control codes, the
// datapath strobes, the register indices and the sign-extended immediate.
// All outputs appear one clock after the instruction is presented.
//
// Optional feature macro: ILLEGAL_TRAP_EN
//   defined   -> o_illegal port exists; an unknown opcode loads a bubble
//                with o_illegal=1.
//   undefined -> no o_illegal port; an unknown opcode loads an architectural
//                NOP (valid, all strobes 0, ALUOP 000, IMM 0).
//
// Ports:
//   i_clk          rising-edge clock
//   i_reset        synchronous, active-high reset
//   i_instr_in     32-bit instruction word from IF/ID
//   i_valid_in     i_instr_in holds a real instruction
//   i_stall        hold every output (hazard unit)
//   i_flush        replace the next output with a bubble
//   o_valid_out    outputs describe a real instruction
//   o_aluop        3-bit class code for the ALU control
//   o_instruccion  {instr[30], instr[14:12]}
//   o_imm          sign-extended immediate, DATA_WIDTH bits
//   o_rd/o_rs1/o_rs2  register indices
//   o_regwrite, o_alusrc, o_memread, o_memwrite, o_memtoreg,
//   o_branch, o_jump, o_jalr   datapath strobes
//   o_illegal      unknown opcode trap (ILLEGAL_TRAP_EN only)
// -----------------------------------------------------------------------------
module unidad_control_id #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [31:0]           i_instr_in,
  input  logic                  i_valid_in,
  input  logic                  i_stall,
  input  logic                  i_flush,
  output logic                  o_valid_out,
  output logic [2:0]            o_aluop,
  output logic [3:0]            o_instruccion,
  output logic [DATA_WIDTH-1:0] o_imm,
  output logic [4:0]            o_rd,
  output logic [4:0]            o_rs1,
  output logic [4:0]            o_rs2,
  output logic                  o_regwrite,
  output logic                  o_alusrc,
  output logic                  o_memread,
  output logic                  o_memwrite,
  output logic                  o_memtoreg,
  output logic                  o_branch,
  output logic                  o_jump,
  output logic                  o_jalr
`ifdef ILLEGAL_TRAP_EN
 ,output logic                  o_illegal
`endif
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  // One packed word holds the whole stage output, so a bubble is simply '0.
  typedef struct packed {
    logic                  valid;
    logic [2:0]            aluop;
    logic [3:0]            instruccion;
    logic [DATA_WIDTH-1:0] imm;
    logic [4:0]            rd;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic                  regwrite;
    logic                  alusrc;
    logic                  memread;
    logic                  memwrite;
    logic                  memtoreg;
    logic                  branch;
    logic                  jump;
    logic                  jalr;
  } decode_t;

  decode_t     w_dec;
  decode_t     r_out;
  logic [31:0] w_imm32;
`ifdef ILLEGAL_TRAP_EN
  logic        w_known;
  logic        r_illegal;
`endif

  // Combinational decode of the incoming word. The immediate is assembled at
  // 32 bits (bit 31 already in the MSB) and then sign-extended to DATA_WIDTH.
  always_comb begin
    w_dec             = '0;
    w_imm32           = '0;
`ifdef ILLEGAL_TRAP_EN
    w_known           = 1'b1;
`endif
    w_dec.valid       = 1'b1;
    w_dec.instruccion = {i_instr_in[30], i_instr_in[14:12]};
    w_dec.rd          = i_instr_in[11:7];
    w_dec.rs1         = i_instr_in[19:15];
    w_dec.rs2         = i_instr_in[24:20];
    case (i_instr_in[6:0])
      OP_R: begin
        w_dec.aluop    = 3'b000;
        w_dec.regwrite = 1'b1;
      end
      OP_IALU: begin
        w_dec.aluop    = 3'b001;
        w_dec.regwrite = 1'b1;
        w_dec.alusrc   = 1'b1;
        w_imm32        = {{20{i_instr_in[31]}}, i_instr_in[31:20]};
      end
      OP_LOAD: begin
        w_dec.aluop    = 3'b010;
        w_dec.regwrite = 1'b1;
        w_dec.alusrc   = 1'b1;
        w_dec.memread  = 1'b1;
        w_dec.memtoreg = 1'b1;
        w_imm32        = {{20{i_instr_in[31]}}, i_instr_in[31:20]};
      end
      OP_STORE: begin
        w_dec.aluop    = 3'b011;
        w_dec.alusrc   = 1'b1;
        w_dec.memwrite = 1'b1;
        w_imm32        = {{20{i_instr_in[31]}}, i_instr_in[31:25], i_instr_in[11:7]};
      end
      OP_BR: begin
        w_dec.aluop    = 3'b100;
        w_dec.branch   = 1'b1;
        w_imm32        = {{19{i_instr_in[31]}}, i_instr_in[31], i_instr_in[7],
                          i_instr_in[30:25], i_instr_in[11:8], 1'b0};
      end
      OP_LUI: begin
        w_dec.aluop    = 3'b101;
        w_dec.regwrite = 1'b1;
        w_dec.alusrc   = 1'b1;
        w_imm32        = {i_instr_in[31:12], 12'b0};
      end
      OP_AUIPC: begin
        w_dec.aluop    = 3'b110;
        w_dec.regwrite = 1'b1;
        w_dec.alusrc   = 1'b1;
        w_imm32        = {i_instr_in[31:12], 12'b0};
      end
      OP_JAL: begin
        w_dec.aluop    = 3'b111;
        w_dec.regwrite = 1'b1;
        w_dec.jump     = 1'b1;
        w_imm32        = {{11{i_instr_in[31]}}, i_instr_in[31], i_instr_in[19:12],
                          i_instr_in[20], i_instr_in[30:21], 1'b0};
      end
      OP_JALR: begin
        w_dec.aluop    = 3'b111;
        w_dec.regwrite = 1'b1;
        w_dec.alusrc   = 1'b1;
        w_dec.jump     = 1'b1;
        w_dec.jalr     = 1'b1;
        w_imm32        = {{20{i_instr_in[31]}}, i_instr_in[31:20]};
      end
      default: begin
`ifdef ILLEGAL_TRAP_EN
        w_known = 1'b0;
`endif
      end
    endcase
    w_dec.imm = DATA_WIDTH'($signed(w_imm32));
`ifdef ILLEGAL_TRAP_EN
    // A trapped opcode travels down the pipe as a bubble.
    if (!w_known) begin
      w_dec = '0;
    end
`endif
  end

  // Stage register: reset, then flush, then stall, then load/bubble.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_out <= '0;
    end else if (i_flush) begin
      r_out <= '0;
    end else if (!i_stall) begin
      if (i_valid_in) begin
        r_out <= w_dec;
      end else begin
        r_out <= '0;
      end
    end
  end

`ifdef ILLEGAL_TRAP_EN
  // The trap flag shares the stage register's priority order.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_flush) begin
      r_illegal <= 1'b0;
    end else if (!i_stall) begin
      r_illegal <= i_valid_in & ~w_known;
    end
  end

  assign o_illegal = r_illegal;
`endif

  assign o_valid_out   = r_out.valid;
  assign o_aluop       = r_out.aluop;
  assign o_instruccion = r_out.instruccion;
  assign o_imm         = r_out.imm;
  assign o_rd          = r_out.rd;
  assign o_rs1         = r_out.rs1;
  assign o_rs2         = r_out.rs2;
  assign o_regwrite    = r_out.regwrite;
  assign o_alusrc      = r_out.alusrc;
  assign o_memread     = r_out.memread;
  assign o_memwrite    = r_out.memwrite;
  assign o_memtoreg    = r_out.memtoreg;
  assign o_branch      = r_out.branch;
  assign o_jump        = r_out.jump;
  assign o_jalr        = r_out.jalr;

endmodule
